// File: rtl/vga_timing_gen.sv
//==============================================================================
// Module   : vga_timing_gen
// Purpose  : VGA raster timing with integrated pixel-clock divider, pixel
//            coordinates, line/frame strobes and a frame-synchronous test pattern.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module vga_timing_gen #(
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter int CE_DIV    = 1,
  parameter int X_W       = 10,
  parameter int Y_W       = 10,
  parameter int CHK_SHIFT = 5
) (
  input  logic           CLK,
  input  logic           reset,
  input  logic [1:0]     mode,
  input  logic [2:0]     pixel_in,
  output logic           hsync,
  output logic           vsync,
  output logic [2:0]     rgb,
  output logic           display_on,
  output logic [X_W-1:0] hpos,
  output logic [Y_W-1:0] vpos,
  output logic           pix_ce,
  output logic           line_start,
  output logic           frame_start,
  output logic [7:0]     frame_cnt
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int BAR_W   = H_DISPLAY / 8;
  localparam int DIV_W   = (CE_DIV > 1) ? $clog2(CE_DIV) : 1;

  localparam logic [X_W-1:0]   H_LAST   = X_W'(H_TOTAL - 1);
  localparam logic [Y_W-1:0]   V_LAST   = Y_W'(V_TOTAL - 1);
  localparam logic [X_W-1:0]   H_VIS    = X_W'(H_DISPLAY);
  localparam logic [Y_W-1:0]   V_VIS    = Y_W'(V_DISPLAY);
  localparam logic [X_W-1:0]   HS_BEG   = X_W'(H_DISPLAY + H_FRONT);
  localparam logic [X_W-1:0]   HS_END   = X_W'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [Y_W-1:0]   VS_BEG   = Y_W'(V_DISPLAY + V_FRONT);
  localparam logic [Y_W-1:0]   VS_END   = Y_W'(V_DISPLAY + V_FRONT + V_SYNC - 1);
  localparam logic [X_W-1:0]   BAR_LAST = X_W'(BAR_W - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CE_DIV - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic [X_W-1:0]   hpos_q, hpos_d;
  logic [Y_W-1:0]   vpos_q, vpos_d;
  logic [X_W-1:0]   bar_cnt_q, bar_cnt_d;
  logic [2:0]       bar_idx_q, bar_idx_d;
  logic [1:0]       mode_q, mode_d;
  logic [7:0]       frame_cnt_q, frame_cnt_d;
  logic [2:0]       rgb_q, rgb_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             display_q, display_d;
  logic             pix_ce_q;
  logic             line_q, line_d;
  logic             frame_q, frame_d;
  logic             pix_en;
  logic             chk;
  logic [2:0]       pattern;

  // Everything is decoded from the next position so that sync, display_on and
  // the registered colour change on the same edge as hpos/vpos.
  always_comb begin
    pix_en    = (div_q == DIV_LAST);
    div_d     = pix_en ? '0 : div_q + 1'b1;
    hpos_d    = hpos_q;
    vpos_d    = vpos_q;
    bar_cnt_d = bar_cnt_q;
    bar_idx_d = bar_idx_q;

    if (pix_en) begin
      if (hpos_q == H_LAST) begin
        hpos_d    = '0;
        bar_cnt_d = '0;
        bar_idx_d = '0;
        vpos_d    = (vpos_q == V_LAST) ? '0 : vpos_q + 1'b1;
      end else begin
        hpos_d = hpos_q + 1'b1;
        if (bar_cnt_q == BAR_LAST) begin
          bar_cnt_d = '0;
          bar_idx_d = bar_idx_q + 1'b1;
        end else begin
          bar_cnt_d = bar_cnt_q + 1'b1;
        end
      end
    end

    line_d      = pix_en && (hpos_d == '0);
    frame_d     = line_d && (vpos_d == '0);
    mode_d      = frame_d ? mode : mode_q;
    frame_cnt_d = frame_d ? frame_cnt_q + 8'd1 : frame_cnt_q;

    display_d = (hpos_d < H_VIS) && (vpos_d < V_VIS);
    hsync_d   = ((hpos_d >= HS_BEG) && (hpos_d <= HS_END)) ? HSYNC_POL : ~HSYNC_POL;
    vsync_d   = ((vpos_d >= VS_BEG) && (vpos_d <= VS_END)) ? VSYNC_POL : ~VSYNC_POL;

    chk = hpos_d[CHK_SHIFT] ^ vpos_d[CHK_SHIFT];
    case (mode_d)
      2'd1:    pattern = ~bar_idx_d;
      2'd2:    pattern = {3{chk}};
      default: pattern = 3'b000;
    endcase
    rgb_d = display_d ? pattern : 3'b000;
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      div_q       <= '0;
      hpos_q      <= H_LAST;
      vpos_q      <= V_LAST;
      bar_cnt_q   <= '0;
      bar_idx_q   <= '0;
      mode_q      <= '0;
      frame_cnt_q <= '0;
      rgb_q       <= '0;
      hsync_q     <= ~HSYNC_POL;
      vsync_q     <= ~VSYNC_POL;
      display_q   <= 1'b0;
      pix_ce_q    <= 1'b0;
      line_q      <= 1'b0;
      frame_q     <= 1'b0;
    end else begin
      div_q       <= div_d;
      hpos_q      <= hpos_d;
      vpos_q      <= vpos_d;
      bar_cnt_q   <= bar_cnt_d;
      bar_idx_q   <= bar_idx_d;
      mode_q      <= mode_d;
      frame_cnt_q <= frame_cnt_d;
      rgb_q       <= rgb_d;
      hsync_q     <= hsync_d;
      vsync_q     <= vsync_d;
      display_q   <= display_d;
      pix_ce_q    <= pix_en;
      line_q      <= line_d;
      frame_q     <= frame_d;
    end
  end

  // External pixels bypass the output register for zero latency.
  assign rgb         = (mode_q == 2'd3) ? (display_q ? pixel_in : 3'b000) : rgb_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign display_on  = display_q;
  assign hpos        = hpos_q;
  assign vpos        = vpos_q;
  assign pix_ce      = pix_ce_q;
  assign line_start  = line_q;
  assign frame_start = frame_q;
  assign frame_cnt   = frame_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
//==============================================================================
// Module   : tb_vga_timing_gen
// Purpose  : Bench for vga_timing_gen: default and small/divided instances
//            compared every cycle against an arithmetic raster model.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_vga_timing_gen;

  typedef struct {
    int hd, hf, hs, hb, vd, vf, vs, vb, cd, cs;
    bit hp, vp;
  } cfg_t;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic [2:0]  rgb;
    logic        don;
    logic [15:0] h;
    logic [15:0] v;
    logic        pce;
    logic        ls;
    logic        fs;
    logic [7:0]  fc;
  } obs_t;

  localparam int NCYC   = 16000;
  localparam int RST_AT = 9000;

  logic       CLK = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] mode = 2'd1;
  logic [2:0] pixel_in = 3'd0;

  logic       a_hs, a_vs, a_don, a_pce, a_ls, a_fs;
  logic [2:0] a_rgb;
  logic [9:0] a_h, a_v;
  logic [7:0] a_fc;
  logic       b_hs, b_vs, b_don, b_pce, b_ls, b_fs;
  logic [2:0] b_rgb;
  logic [5:0] b_h;
  logic [4:0] b_v;
  logic [7:0] b_fc;

  obs_t oa, ob;
  cfg_t ca, cb;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 CLK = ~CLK;

  vga_timing_gen u_def (
    .CLK(CLK), .reset(reset), .mode(mode), .pixel_in(pixel_in),
    .hsync(a_hs), .vsync(a_vs), .rgb(a_rgb), .display_on(a_don),
    .hpos(a_h), .vpos(a_v), .pix_ce(a_pce), .line_start(a_ls),
    .frame_start(a_fs), .frame_cnt(a_fc)
  );

  vga_timing_gen #(
    .H_DISPLAY(32), .H_FRONT(4), .H_SYNC(6), .H_BACK(6),
    .V_DISPLAY(16), .V_FRONT(2), .V_SYNC(3), .V_BACK(3),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .CE_DIV(3),
    .X_W(6), .Y_W(5), .CHK_SHIFT(2)
  ) u_small (
    .CLK(CLK), .reset(reset), .mode(mode), .pixel_in(pixel_in),
    .hsync(b_hs), .vsync(b_vs), .rgb(b_rgb), .display_on(b_don),
    .hpos(b_h), .vpos(b_v), .pix_ce(b_pce), .line_start(b_ls),
    .frame_start(b_fs), .frame_cnt(b_fc)
  );

  assign oa = {a_hs, a_vs, a_rgb, a_don, 16'(a_h), 16'(a_v), a_pce, a_ls, a_fs, a_fc};
  assign ob = {b_hs, b_vs, b_rgb, b_don, 16'(b_h), 16'(b_v), b_pce, b_ls, b_fs, b_fc};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Raster position index after k clock edges since reset release.
  function automatic int pos_of(input cfg_t c, input int k);
    int ht, tot;
    ht  = c.hd + c.hf + c.hs + c.hb;
    tot = ht * (c.vd + c.vf + c.vs + c.vb);
    return ((k / c.cd) + tot - 1) % tot;
  endfunction

  function automatic bit don_of(input cfg_t c, input int k);
    int ht, p;
    ht = c.hd + c.hf + c.hs + c.hb;
    p  = pos_of(c, k);
    return ((p % ht) < c.hd) && ((p / ht) < c.vd);
  endfunction

  task automatic check_inst(input string nm, input cfg_t c, input obs_t o, input int k,
                            input int mode_app, input logic [2:0] pix, inout int fm);
    int ht, tot, e, p, h, v, fc, exp_rgb;
    bit pce, fs, ls, don, hs, vs;
    ht  = c.hd + c.hf + c.hs + c.hb;
    tot = ht * (c.vd + c.vf + c.vs + c.vb);
    e   = k / c.cd;
    pce = (k > 0) && (k % c.cd == 0);
    p   = pos_of(c, k);
    h   = p % ht;
    v   = p / ht;
    ls  = pce && (h == 0);
    fs  = pce && (p == 0);
    fc  = ((e + tot - 1) / tot) % 256;
    don = (h < c.hd) && (v < c.vd);
    hs  = (h >= c.hd + c.hf && h < c.hd + c.hf + c.hs) ? c.hp : !c.hp;
    vs  = (v >= c.vd + c.vf && v < c.vd + c.vf + c.vs) ? c.vp : !c.vp;
    if (fs) fm = mode_app;
    if (!don) exp_rgb = 0;
    else begin
      case (fm)
        1:       exp_rgb = 7 - h / (c.hd / 8);
        2:       exp_rgb = (((h >> c.cs) ^ (v >> c.cs)) & 1) != 0 ? 7 : 0;
        3:       exp_rgb = int'(pix);
        default: exp_rgb = 0;
      endcase
    end
    check({nm, ".hpos"},        32'(o.h),   h);
    check({nm, ".vpos"},        32'(o.v),   v);
    check({nm, ".hsync"},       32'(o.hs),  32'(hs));
    check({nm, ".vsync"},       32'(o.vs),  32'(vs));
    check({nm, ".display_on"},  32'(o.don), 32'(don));
    check({nm, ".pix_ce"},      32'(o.pce), 32'(pce));
    check({nm, ".line_start"},  32'(o.ls),  32'(ls));
    check({nm, ".frame_start"}, 32'(o.fs),  32'(fs));
    check({nm, ".frame_cnt"},   32'(o.fc),  fc);
    check({nm, ".rgb"},         32'(o.rgb), exp_rgb);
  endtask

  initial begin
    int k, fm_a, fm_b, mode_app, ht_b, tot_b;
    ca = '{hd:640, hf:16, hs:96, hb:48, vd:480, vf:10, vs:2, vb:33, cd:1, cs:5, hp:1'b0, vp:1'b0};
    cb = '{hd:32, hf:4, hs:6, hb:6, vd:16, vf:2, vs:3, vb:3, cd:3, cs:2, hp:1'b1, vp:1'b1};
    ht_b  = 48;
    tot_b = 48 * 24;
    k = 0; fm_a = 0; fm_b = 0;
    mode_app = 1;

    for (int i = 0; i < NCYC; i++) begin
      @(negedge CLK);
      if (reset) begin
        k = 0; fm_a = 0; fm_b = 0;
      end else begin
        k++;
      end
      check_inst("A", ca, oa, k, mode_app, pixel_in, fm_a);
      check_inst("B", cb, ob, k, mode_app, pixel_in, fm_b);

      if (i == 2 || i == RST_AT + 3) reset = 1'b0;
      if (i == RST_AT) begin
        reset = 1'b1;
        #1;
        k = 0; fm_a = 0; fm_b = 0;
        check_inst("A.async", ca, oa, k, mode_app, pixel_in, fm_a);
        check_inst("B.async", cb, ob, k, mode_app, pixel_in, fm_b);
      end

      // Step the mode on the edge that wraps B to (0,0); otherwise change rarely.
      if (!reset && ((k + 1) % 3 == 0) && (((k + 1) / 3) % tot_b == 1))
        mode = mode + 2'd1;
      else if ($urandom_range(0, 299) == 0)
        mode = 2'($urandom_range(0, 3));
      mode_app = int'(mode);
      pixel_in = 3'($urandom);

      #1;
      if (fm_a == 3) check("A.rgb_comb", 32'(a_rgb), don_of(ca, k) ? 32'(pixel_in) : 32'd0);
      if (fm_b == 3) check("B.rgb_comb", 32'(b_rgb), don_of(cb, k) ? 32'(pixel_in) : 32'd0);
    end

    if (ht_b != 48) $display("note: unexpected line length");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
